// File: rtl/msg_pkg.sv
// Shared FSM state type and header layout for the message framer.
// The length field sits at HDR_LEN_LSB; HDR_LEN_WIDTH is the default beat-length width.
package msg_pkg;
  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DISCARD = 2'd1,
    HEADER  = 2'd2,
    DRAIN   = 2'd3
  } msg_state_e;

  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_LEN_WIDTH = 16;
endpackage

// File: rtl/msg_beat_fifo.sv
// Payload beat store for one message: write/read pointers, registered read port,
// and a flush that rewinds both pointers so a dropped or finished message leaves nothing behind.
module msg_beat_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [WIDTH-1:0] rd_data_r;

  // Pointer state; flush takes priority over any traffic in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write and registered read; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
    if (rd_en) begin
      rd_data_r <= mem_r[rd_ptr_r];
    end
  end

  assign rd_data = rd_data_r;
endmodule

// File: rtl/msg_framer.sv
// Store-and-forward framer: buffers a whole message, then emits a length header
// followed by the payload; messages longer than FIFO_DEPTH are dropped with err_oversize.
module msg_framer
  import msg_pkg::*;
#(
  parameter int DATA_BYTES     = 8,
  parameter int NUM_COUNT_BITS = HDR_LEN_WIDTH,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [DATA_BYTES*8-1:0] s_tdata,
  input  logic                    s_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_BYTES*8-1:0] m_tdata,
  output logic                    m_tlast,
  output logic                    msg_done,
  output logic                    err_oversize
);
  localparam int DW = DATA_BYTES * 8;
  localparam logic [NUM_COUNT_BITS-1:0] CNT_MAX  = NUM_COUNT_BITS'(FIFO_DEPTH);
  localparam logic [NUM_COUNT_BITS-1:0] CNT_ONE  = NUM_COUNT_BITS'(1);
  localparam logic [NUM_COUNT_BITS-1:0] CNT_ZERO = {NUM_COUNT_BITS{1'b0}};

  msg_state_e               state_r, state_s;
  logic [NUM_COUNT_BITS-1:0] cnt_r, cnt_s;
  logic                     wr_en_s, rd_en_s, flush_s, done_s, err_s;
  logic                     s_hs_s, m_hs_s;
  logic                     m_tvalid_r, m_tlast_r, msg_done_r, err_oversize_r;
  logic [DW-1:0]            fifo_rd_data_s, m_tdata_s;

  assign s_tready = ~rst & ((state_r == FILL) | (state_r == DISCARD));
  assign s_hs_s   = s_tvalid & s_tready;
  assign m_hs_s   = m_tvalid_r & m_tready;

  msg_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_s),
    .wr_en   (wr_en_s),
    .wr_data (s_tdata),
    .rd_en   (rd_en_s),
    .rd_data (fifo_rd_data_s)
  );

  // Next-state, beat count and buffer control.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    flush_s = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      FILL: begin
        // A beat beyond FIFO_DEPTH drops the message, even if it is the last one.
        if (s_hs_s && (cnt_r == CNT_MAX)) begin
          err_s   = 1'b1;
          flush_s = 1'b1;
          cnt_s   = CNT_ZERO;
          state_s = s_tlast ? FILL : DISCARD;
        end else if (s_hs_s) begin
          wr_en_s = 1'b1;
          cnt_s   = cnt_r + CNT_ONE;
          state_s = s_tlast ? HEADER : FILL;
        end else begin
          state_s = FILL;
        end
      end
      DISCARD: begin
        if (s_hs_s && s_tlast) begin
          cnt_s   = CNT_ZERO;
          state_s = FILL;
        end else begin
          state_s = DISCARD;
        end
      end
      HEADER: begin
        // Prefetch the first payload beat so DRAIN starts without a bubble.
        if (m_hs_s) begin
          rd_en_s = 1'b1;
          state_s = DRAIN;
        end else begin
          state_s = HEADER;
        end
      end
      DRAIN: begin
        if (m_hs_s && (cnt_r == CNT_ONE)) begin
          done_s  = 1'b1;
          flush_s = 1'b1;
          cnt_s   = CNT_ZERO;
          state_s = FILL;
        end else if (m_hs_s) begin
          rd_en_s = 1'b1;
          cnt_s   = cnt_r - CNT_ONE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        flush_s = 1'b1;
        cnt_s   = CNT_ZERO;
        state_s = FILL;
      end
    endcase
  end

  // State, count and registered output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= FILL;
      cnt_r          <= CNT_ZERO;
      m_tvalid_r     <= 1'b0;
      m_tlast_r      <= 1'b0;
      msg_done_r     <= 1'b0;
      err_oversize_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      m_tvalid_r     <= (state_s == HEADER) || (state_s == DRAIN);
      m_tlast_r      <= (state_s == DRAIN) && (cnt_s == CNT_ONE);
      msg_done_r     <= done_s;
      err_oversize_r <= err_s;
    end
  end

  // Output data: length header in HEADER, buffered payload otherwise.
  always_comb begin
    m_tdata_s = {DW{1'b0}};
    if (state_r == HEADER) begin
      m_tdata_s[HDR_LEN_LSB +: NUM_COUNT_BITS] = cnt_r;
    end else begin
      m_tdata_s = fifo_rd_data_s;
    end
  end

  assign m_tvalid     = m_tvalid_r;
  assign m_tlast      = m_tlast_r;
  assign m_tdata      = m_tdata_s;
  assign msg_done     = msg_done_r;
  assign err_oversize = err_oversize_r;
endmodule

// File: tb/tb_msg_framer.sv
// Randomized bench for msg_framer: expected output frames are built from each sent
// message (header = length, then payload) and compared beat by beat on every handshake.
module tb_msg_framer;
  localparam int DW    = 64;
  localparam int DEPTH = 64;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic          msg_done, err_oversize;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  int    exp_done = 0, exp_err = 0;
  int    done_seen = 0, err_seen = 0, out_beats = 0;
  int    rmode = 0;

  logic          prev_stall = 1'b0, prev_hs_nl = 1'b0, pend_done = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  msg_framer dut (
    .clk          (clk),
    .rst          (rst),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast),
    .msg_done     (msg_done),
    .err_oversize (err_oversize)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = random gaps, other = test drives it.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: m_tready = 1'b1;
      1: m_tready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  end

  // Compare process: every output handshake against the expected frame queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_hs_nl = 1'b0;
      pend_done  = 1'b0;
    end else begin
      if (msg_done) done_seen++;
      if (err_oversize) err_seen++;
      if (prev_stall) begin
        chk(m_tvalid, "stall_valid", DW'(m_tvalid), 64'd1);
        chk(m_tdata == prev_d, "stall_data", m_tdata, prev_d);
        chk(m_tlast == prev_l, "stall_last", DW'(m_tlast), DW'(prev_l));
      end
      if (prev_hs_nl) chk(m_tvalid, "no_bubble", DW'(m_tvalid), 64'd1);
      chk(msg_done == pend_done, "msg_done", DW'(msg_done), DW'(pend_done));
      if (m_tvalid && m_tready) begin
        out_beats++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", m_tdata, 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk(m_tdata == e.d, "beat_data", m_tdata, e.d);
          chk(m_tlast == e.l, "beat_last", DW'(m_tlast), DW'(e.l));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
      prev_hs_nl = m_tvalid && m_tready && !m_tlast;
      pend_done  = m_tvalid && m_tready && m_tlast;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (!s_tready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(s_tready, "s_tready_timeout", DW'(n), 64'd3000);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_message(input int len, input logic [DW-1:0] hdr_lit, input bit gaps);
    logic [DW-1:0] d;
    if (len <= DEPTH) begin
      exp_q.push_back('{DW'(len), 1'b0});
      exp_done++;
    end else begin
      exp_err++;
    end
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      if (len <= DEPTH) exp_q.push_back('{d, (i == len - 1)});
      if (gaps && $urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
      send_beat(d, (i == len - 1));
    end
    if (len <= DEPTH) begin
      chk(m_tvalid, "hdr_valid_next_cycle", DW'(m_tvalid), 64'd1);
      chk(m_tdata == DW'(len), "hdr_len", m_tdata, DW'(len));
      if (hdr_lit != 64'd0) chk(m_tdata == hdr_lit, "hdr_literal", m_tdata, hdr_lit);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n < 4000, "drain_timeout", DW'(n), 64'd4000);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, e0, b0;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 64'd0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(s_tready == 1'b0, "rst_s_tready", DW'(s_tready), 64'd0);
    chk(m_tvalid == 1'b0, "rst_m_tvalid", DW'(m_tvalid), 64'd0);
    chk(msg_done == 1'b0, "rst_msg_done", DW'(msg_done), 64'd0);
    chk(err_oversize == 1'b0, "rst_err", DW'(err_oversize), 64'd0);
    rst = 1'b0;
    #1;
    chk(s_tready == 1'b1, "post_rst_s_tready", DW'(s_tready), 64'd1);

    // Three-beat message, then a single-beat message.
    d0 = done_seen;
    send_message(3, 64'd3, 1'b0);
    wait_idle();
    chk(done_seen - d0 == 1, "done_once_3beat", DW'(done_seen - d0), 64'd1);
    send_message(1, 64'd1, 1'b0);
    wait_idle();

    // Exactly FIFO_DEPTH beats frames normally.
    e0 = err_seen;
    send_message(64, 64'd64, 1'b0);
    wait_idle();
    chk(err_seen == e0, "no_err_64beat", DW'(err_seen - e0), 64'd0);

    // One beat too many is dropped, then a 2-beat message.
    e0 = err_seen;
    send_message(65, 64'd0, 1'b0);
    @(posedge clk); #1;
    chk(err_seen - e0 == 1, "err_once_65beat", DW'(err_seen - e0), 64'd1);
    chk(m_tvalid == 1'b0, "oversize_no_output", DW'(m_tvalid), 64'd0);
    send_message(2, 64'd2, 1'b0);
    wait_idle();

    // Random ready gaps while draining 5 beats.
    rmode = 1;
    b0 = out_beats;
    send_message(5, 64'd5, 1'b0);
    wait_idle();
    chk(out_beats - b0 == 6, "beats_5beat", DW'(out_beats - b0), 64'd6);

    // Reset in the middle of DRAIN.
    rmode = 2;
    m_tready = 1'b0;
    send_message(4, 64'd4, 1'b0);
    m_tready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_done--;
    @(posedge clk); #1;
    chk(m_tvalid == 1'b0, "mid_rst_m_tvalid", DW'(m_tvalid), 64'd0);
    chk(s_tready == 1'b0, "mid_rst_s_tready", DW'(s_tready), 64'd0);
    rst = 1'b0;
    #1;
    chk(s_tready == 1'b1, "after_rst_fill", DW'(s_tready), 64'd1);
    rmode = 0;
    send_message(1, 64'd1, 1'b0);
    wait_idle();

    // Random messages, some oversized, with input gaps and random ready.
    for (int k = 0; k < 16; k++) begin
      rmode = $urandom_range(0, 1);
      send_message($urandom_range(1, 70), 64'd0, 1'b1);
    end
    wait_idle();

    chk(done_seen == exp_done, "done_total", DW'(done_seen), DW'(exp_done));
    chk(err_seen == exp_err, "err_total", DW'(err_seen), DW'(exp_err));
    chk(exp_q.size() == 0, "queue_empty", DW'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule

// File: doc/msg_framer.md
MSG_FRAMER -- requirements
Module: msg_framer

Interface
REQ-001 The block SHALL have parameter DATA_BYTES, default 8, meaning the stream data width in bytes.
REQ-002 The block SHALL have parameter NUM_COUNT_BITS, default 16, meaning the width of the beat-length field.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 64, meaning the maximum message length in beats; legal values are powers of two with FIFO_DEPTH <= 2**NUM_COUNT_BITS - 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have ports s_tvalid (in, 1), s_tready (out, 1), s_tdata (in, DATA_BYTES*8) and s_tlast (in, 1), forming the input message stream.
REQ-007 The block SHALL have ports m_tvalid (out, 1), m_tready (in, 1), m_tdata (out, DATA_BYTES*8) and m_tlast (out, 1), forming the framed output stream.
REQ-008 The block SHALL have port msg_done, output, 1 bit: a one-cycle pulse when the last payload beat of a message is accepted downstream.
REQ-009 The block SHALL have port err_oversize, output, 1 bit: a one-cycle pulse when a message is dropped for exceeding FIFO_DEPTH.

Function
REQ-010 The block SHALL store each input message in full before output starts, then emit one header beat followed by the stored payload beats.
REQ-011 The FSM SHALL have exactly four states: FILL, DISCARD, HEADER and DRAIN; it resets to FILL.
REQ-012 A beat SHALL transfer on either stream only in a cycle where tvalid and tready are both 1.
REQ-013 s_tready SHALL be 1 in FILL and DISCARD, and 0 in HEADER and DRAIN.
REQ-014 In FILL, each accepted beat SHALL be written to the buffer and SHALL increment the beat count by exactly 1.
REQ-015 In FILL, an accepted beat with s_tlast=1 SHALL move the FSM to HEADER on the next cycle, with the count including that beat.
REQ-016 In FILL, if a beat is accepted with s_tlast=0 while the count already equals FIFO_DEPTH, the block SHALL pulse err_oversize, discard the stored beats and enter DISCARD.
REQ-017 In DISCARD, the block SHALL accept and drop beats; an accepted s_tlast=1 beat SHALL return the FSM to FILL with the count set to 0.
REQ-018 A message of exactly FIFO_DEPTH beats whose final beat carries s_tlast=1 SHALL be framed normally and SHALL NOT raise err_oversize.
REQ-019 In HEADER, the block SHALL drive m_tvalid=1, m_tlast=0, the count zero-extended in the low bits of m_tdata, and all other m_tdata bits as 0.
REQ-020 In HEADER, a downstream handshake SHALL move the FSM to DRAIN.
REQ-021 In DRAIN, payload beats SHALL leave in arrival order, with m_tlast=1 only on the final stored beat.
REQ-022 In DRAIN, with m_tready held at 1, the block SHALL deliver one beat per cycle with no bubbles, including the header-to-first-payload transition.
REQ-023 On the handshake of the m_tlast beat, the block SHALL pulse msg_done, clear the count, and return to FILL on the next cycle.
REQ-024 While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tvalid SHALL hold stable.
REQ-025 The header SHALL be presented (m_tvalid=1) in the cycle immediately after the s_tlast beat is accepted.
REQ-026 The count SHALL NOT wrap, because it is bounded by FIFO_DEPTH.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL enter FILL with the count at 0, buffer pointers at 0, m_tvalid=0, msg_done=0 and err_oversize=0.
REQ-028 During reset, the block SHALL drive s_tready=0; s_tready SHALL equal 1 in the first cycle after rst deasserts.
REQ-029 A reset in any state SHALL abandon the in-flight message without emitting a partial frame.
REQ-030 m_tdata SHALL NOT require a reset value.

Structure
REQ-031 A shared package msg_pkg SHALL hold the state enum and the header-field constants (length LSB position and width).
REQ-032 The payload storage SHALL be one sub-module, msg_beat_fifo: FIFO_DEPTH x (DATA_BYTES*8) storage with write/read pointers, registered read and a flush input.
REQ-033 The beat counter and the FSM SHALL be implemented in msg_framer itself.

Verification
REQ-034 Three-beat message (A,B,C, last on C) with m_tready=1 -> output header=3, then A, B, C, m_tlast only on C, msg_done pulses once.
REQ-035 Single-beat message D -> output header=1, then D with m_tlast=1.
REQ-036 64-beat message with FIFO_DEPTH=64 -> header=64, then 64 payload beats, err_oversize stays 0.
REQ-037 65-beat message followed by a 2-beat message -> err_oversize pulses once, nothing from the 65-beat message is output, then header=2 and the 2 payload beats.
REQ-038 Random m_tready gaps during DRAIN of a 5-beat message -> data stays stable while stalled, order is preserved, and exactly 6 output beats occur.
REQ-039 rst asserted mid-DRAIN of a 4-beat message -> m_tvalid=0 the next cycle, FSM in FILL, and a following 1-beat message yields header=1.
